// File: rtl/graph_slice_engine.sv
// Graph Mode slice engine: copies a fixed-width column window from every row of a
// row-major INT8 tensor in SRAM0 into a packed destination, one byte per cycle.
module graph_slice_engine #(
  parameter int unsigned SRAM0_AW = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  input  logic [15:0]         cmd_src_base_i,
  input  logic [15:0]         cmd_dst_base_i,
  input  logic [15:0]         cmd_src_row_len_i,
  input  logic [15:0]         cmd_dst_row_len_i,
  input  logic [15:0]         cmd_start_offset_i,
  input  logic [15:0]         cmd_num_rows_i,
  output logic                rd_en_o,
  output logic [SRAM0_AW-1:0] rd_addr_o,
  input  logic [7:0]          rd_data_i,
  output logic                wr_en_o,
  output logic [SRAM0_AW-1:0] wr_addr_o,
  output logic [7:0]          wr_data_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] src_row_len_q, src_row_len_d;
  logic [15:0] dst_row_len_q, dst_row_len_d;
  logic [15:0] num_rows_q, num_rows_d;
  logic [15:0] row_base_q, row_base_d;
  logic [15:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] dst_ptr_q, dst_ptr_d;
  logic [15:0] wr_ptr_q, wr_ptr_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        last_col, last_row;
  logic [15:0] next_row_base;
  logic [15:0] first_src;

  assign last_col      = (col_q == dst_row_len_q - 16'd1);
  assign last_row      = (row_q == num_rows_q - 16'd1);
  assign next_row_base = row_base_q + src_row_len_q;
  assign first_src     = cmd_src_base_i + cmd_start_offset_i;

  always_comb begin
    state_d       = state_q;
    src_row_len_d = src_row_len_q;
    dst_row_len_d = dst_row_len_q;
    num_rows_d    = num_rows_q;
    row_base_d    = row_base_q;
    rd_ptr_d      = rd_ptr_q;
    col_d         = col_q;
    row_d         = row_q;
    rd_en_d       = 1'b0;
    // The write for a read lands one cycle later at that read's destination byte.
    wr_en_d       = rd_en_q;
    wr_ptr_d      = rd_en_q ? dst_ptr_q : wr_ptr_q;
    dst_ptr_d     = rd_en_q ? dst_ptr_q + 16'd1 : dst_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          src_row_len_d = cmd_src_row_len_i;
          dst_row_len_d = cmd_dst_row_len_i;
          num_rows_d    = cmd_num_rows_i;
          if (cmd_num_rows_i == 16'd0 || cmd_dst_row_len_i == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d    = StRun;
            rd_en_d    = 1'b1;
            rd_ptr_d   = first_src;
            row_base_d = first_src;
            col_d      = 16'd0;
            row_d      = 16'd0;
            dst_ptr_d  = cmd_dst_base_i;
          end
        end
      end
      StRun: begin
        if (last_col && last_row) begin
          state_d = StDrain;
        end else if (last_col) begin
          rd_en_d    = 1'b1;
          col_d      = 16'd0;
          row_d      = row_q + 16'd1;
          row_base_d = next_row_base;
          rd_ptr_d   = next_row_base;
        end else begin
          rd_en_d  = 1'b1;
          col_d    = col_q + 16'd1;
          rd_ptr_d = rd_ptr_q + 16'd1;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      src_row_len_q <= '0;
      dst_row_len_q <= '0;
      num_rows_q    <= '0;
      row_base_q    <= '0;
      rd_ptr_q      <= '0;
      dst_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      col_q         <= '0;
      row_q         <= '0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_row_len_q <= src_row_len_d;
      dst_row_len_q <= dst_row_len_d;
      num_rows_q    <= num_rows_d;
      row_base_q    <= row_base_d;
      rd_ptr_q      <= rd_ptr_d;
      dst_ptr_q     <= dst_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      col_q         <= col_d;
      row_q         <= row_d;
      rd_en_q       <= rd_en_d;
      wr_en_q       <= wr_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_ptr_q[SRAM0_AW-1:0];
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_ptr_q[SRAM0_AW-1:0];
  assign wr_data_o = rd_data_i;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_graph_slice_engine.sv
// Self-checking bench for graph_slice_engine: SRAM0 model plus a sequential copy
// reference that predicts read addresses, timing and final memory contents.
module tb_graph_slice_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [15:0] cmd_src_base, cmd_dst_base, cmd_src_row_len;
  logic [15:0] cmd_dst_row_len, cmd_start_offset, cmd_num_rows;
  logic        rd_en, wr_en, busy, done;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  rd_data, wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  exp_mem [0:65535];
  logic [15:0] exp_rd  [$];

  always #5 clk = ~clk;

  // Synchronous read port; writes are applied by the monitor in the stimulus process.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  graph_slice_engine #(.SRAM0_AW(16)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cmd_valid_i        (cmd_valid),
    .cmd_src_base_i     (cmd_src_base),
    .cmd_dst_base_i     (cmd_dst_base),
    .cmd_src_row_len_i  (cmd_src_row_len),
    .cmd_dst_row_len_i  (cmd_dst_row_len),
    .cmd_start_offset_i (cmd_start_offset),
    .cmd_num_rows_i     (cmd_num_rows),
    .rd_en_o            (rd_en),
    .rd_addr_o          (rd_addr),
    .rd_data_i          (rd_data),
    .wr_en_o            (wr_en),
    .wr_addr_o          (wr_addr),
    .wr_data_o          (wr_data),
    .busy_o             (busy),
    .done_o             (done)
  );

  task automatic drive_cmd(input logic [15:0] sb, db, srl, drl, so, nr);
    cmd_valid        = 1'b1;
    cmd_src_base     = sb;
    cmd_dst_base     = db;
    cmd_src_row_len  = srl;
    cmd_dst_row_len  = drl;
    cmd_start_offset = so;
    cmd_num_rows     = nr;
  endtask

  // Must be entered at a falling edge; returns at the falling edge of cycle done+1.
  task automatic run_cmd(input logic [15:0] sb, db, srl, drl, so, nr, input int strobe_cyc,
                         output int done_at, output int wr_cnt);
    int n, done_exp, rd_cnt, diffs;
    logic [15:0] a_s, a_d;
    n = int'(nr) * int'(drl);
    done_exp = (n == 0) ? 1 : n + 2;
    rd_cnt = 0; wr_cnt = 0; done_at = -1; diffs = 0;
    exp_rd.delete();
    for (int i = 0; i < 65536; i++) exp_mem[i] = mem[i];
    for (int r = 0; r < int'(nr); r++) begin
      for (int c = 0; c < int'(drl); c++) begin
        a_s = sb + 16'(r) * srl + so + 16'(c);
        a_d = db + 16'(r) * drl + 16'(c);
        exp_rd.push_back(a_s);
        exp_mem[a_d] = exp_mem[a_s];
      end
    end
    drive_cmd(sb, db, srl, drl, so, nr);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= done_exp + 1; cyc++) begin
      if (rd_en) begin
        checks++;
        if (rd_cnt >= exp_rd.size() || cyc != rd_cnt + 1 || rd_addr !== exp_rd[rd_cnt]) begin
          errors++;
          $display("FAIL read cyc=%0d idx=%0d got addr %h", cyc, rd_cnt, rd_addr);
        end
        rd_cnt++;
      end
      if (wr_en) begin
        checks++;
        if (cyc != wr_cnt + 2) begin
          errors++;
          $display("FAIL write_cycle got cyc %0d want %0d", cyc, wr_cnt + 2);
        end
        mem[wr_addr] = wr_data;
        wr_cnt++;
      end
      checks++;
      if (done !== (cyc == done_exp)) begin
        errors++;
        $display("FAIL done cyc=%0d got %b want %b", cyc, done, cyc == done_exp);
      end
      if (done === 1'b1 && done_at < 0) done_at = cyc;
      checks++;
      if (busy !== (cyc <= done_exp)) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, cyc <= done_exp);
      end
      if (cyc == strobe_cyc) begin
        drive_cmd(16'($urandom), 16'($urandom), 16'($urandom_range(1, 9)),
                  16'($urandom_range(1, 9)), 16'($urandom_range(0, 5)),
                  16'($urandom_range(1, 4)));
      end else begin
        cmd_valid = 1'b0;
      end
      if (cyc != done_exp + 1) @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (rd_cnt != n) begin
      errors++;
      $display("FAIL read_count got %0d want %0d", rd_cnt, n);
    end
    checks++;
    if (wr_cnt != n) begin
      errors++;
      $display("FAIL write_count got %0d want %0d", wr_cnt, n);
    end
    for (int i = 0; i < 65536; i++) if (mem[i] !== exp_mem[i]) diffs++;
    checks++;
    if (diffs != 0) begin
      errors++;
      $display("FAIL memory got %0d differing bytes want 0", diffs);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({rd_en, wr_en, busy, done} !== 4'b0 || rd_addr !== 16'h0 || wr_addr !== 16'h0) begin
      errors++;
      $display("FAIL %s got rd_en=%b wr_en=%b busy=%b done=%b rd_addr=%h wr_addr=%h want all 0",
               tag, rd_en, wr_en, busy, done, rd_addr, wr_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    drive_cmd(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    int done_at, wr_cnt;
    logic [7:0] want [9];
    want = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
    for (int i = 0; i < 15; i++) mem[16'h100 + 16'(i)] = 8'(i);
    run_cmd(16'h100, 16'h200, 16'd5, 16'd3, 16'd1, 16'd3, 0, done_at, wr_cnt);
    checks++;
    if (done_at != 11) begin
      errors++;
      $display("FAIL basic_done_cycle got %0d want 11", done_at);
    end
    checks++;
    if (wr_cnt != 9) begin
      errors++;
      $display("FAIL basic_writes got %0d want 9", wr_cnt);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (mem[16'h200 + 16'(i)] !== want[i]) begin
        errors++;
        $display("FAIL basic_byte%0d got %0d want %0d", i, mem[16'h200 + 16'(i)], want[i]);
      end
    end
  endtask

  task automatic test_zero();
    int done_at, wr_cnt;
    run_cmd(16'h1000, 16'h2000, 16'd4, 16'd3, 16'd0, 16'd0, 0, done_at, wr_cnt);
    checks++;
    if (done_at != 1) begin
      errors++;
      $display("FAIL zero_rows_done got %0d want 1", done_at);
    end
    run_cmd(16'h1000, 16'h2000, 16'd4, 16'd0, 16'd0, 16'd4, 0, done_at, wr_cnt);
    checks++;
    if (done_at != 1) begin
      errors++;
      $display("FAIL zero_cols_done got %0d want 1", done_at);
    end
  endtask

  task automatic test_strobe();
    int done_at, wr_cnt;
    run_cmd(16'h0700, 16'h0800, 16'd6, 16'd4, 16'd1, 16'd3, 3, done_at, wr_cnt);
    run_cmd(16'h0900, 16'h0A00, 16'd6, 16'd4, 16'd2, 16'd3, 14, done_at, wr_cnt);
  endtask

  task automatic test_wrap();
    int done_at, wr_cnt;
    run_cmd(16'hFFFE, 16'h4000, 16'd4, 16'd4, 16'd0, 16'd1, 0, done_at, wr_cnt);
  endtask

  task automatic test_reset_mid();
    int done_at, wr_cnt;
    logic [7:0] guard;
    guard = ~mem[16'h0502];
    mem[16'h0602] = guard;
    drive_cmd(16'h0500, 16'h0600, 16'd5, 16'd5, 16'd0, 16'd4);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc < 4; cyc++) begin
      if (wr_en) mem[wr_addr] = wr_data;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got done=%b busy=%b want 0", done, busy);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem[16'h0601] !== mem[16'h0501] || mem[16'h0602] !== guard) begin
      errors++;
      $display("FAIL partial_writes got %h/%h want %h/%h", mem[16'h0601], mem[16'h0602],
               mem[16'h0501], guard);
    end
    run_cmd(16'h0500, 16'h0600, 16'd5, 16'd5, 16'd0, 16'd4, 0, done_at, wr_cnt);
  endtask

  task automatic test_inplace();
    int done_at, wr_cnt;
    logic [7:0] orig [32];
    for (int i = 0; i < 32; i++) begin
      orig[i] = 8'($urandom);
      mem[16'h300 + 16'(i)] = orig[i];
    end
    run_cmd(16'h300, 16'h300, 16'd8, 16'd4, 16'd2, 16'd4, 0, done_at, wr_cnt);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (mem[16'h300 + 16'(r * 4 + c)] !== orig[r * 8 + 2 + c]) begin
          errors++;
          $display("FAIL inplace r%0d c%0d got %h want %h", r, c,
                   mem[16'h300 + 16'(r * 4 + c)], orig[r * 8 + 2 + c]);
        end
      end
    end
  endtask

  // Commands issued the cycle after each done, with random fields and stray strobes.
  task automatic test_back_to_back();
    int done_at, wr_cnt, nr, drl, strobe;
    for (int k = 0; k < 8; k++) begin
      nr  = $urandom_range(0, 5);
      drl = $urandom_range(0, 8);
      strobe = ($urandom_range(0, 1) == 1) ? $urandom_range(1, nr * drl + 2) : 0;
      if (nr * drl == 0) strobe = 0;
      run_cmd(16'($urandom_range(16'h1000, 16'h6FFF)), 16'($urandom_range(16'h9000, 16'hEFFF)),
              16'($urandom_range(1, 16)), 16'(drl), 16'($urandom_range(0, 8)), 16'(nr),
              strobe, done_at, wr_cnt);
    end
  endtask

  initial begin
    rd_data = 8'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_zero();
    test_strobe();
    test_wrap();
    test_reset_mid();
    test_inplace();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/graph_slice_engine.md
# graph_slice_engine

Graph Mode slice engine. Sits directly downstream of the graph dispatch stage: it accepts one `sl_cmd_*` command, copies a fixed-width column window out of every row of a row-major INT8 tensor in SRAM0 into a packed destination tensor, and returns a one-cycle `done` that the dispatcher consumes as `sl_done`. It moves one byte per cycle through a single read port and a single write port on SRAM0. The SRAM mux arbitrates the SRAM0 ports; this engine does not arbitrate.

## Interface
- `SRAM0_AW`, 16: SRAM0 byte address width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: single-cycle command strobe.
- `cmd_src_base` input 16: byte address of source row 0.
- `cmd_dst_base` input 16: byte address of destination row 0.
- `cmd_src_row_len` input 16: source row pitch, in bytes.
- `cmd_dst_row_len` input 16: bytes copied per row; also the destination pitch.
- `cmd_start_offset` input 16: column of the first copied byte within each source row.
- `cmd_num_rows` input 16: number of rows.
- `rd_en` output 1: SRAM0 read enable.
- `rd_addr` output SRAM0_AW: SRAM0 read address.
- `rd_data` input 8: SRAM0 read data, valid the cycle after `rd_en`.
- `wr_en` output 1: SRAM0 write enable.
- `wr_addr` output SRAM0_AW: SRAM0 write address.
- `wr_data` output 8: SRAM0 write data.
- `busy` output 1: the engine is executing a command.
- `done` output 1: one-cycle completion pulse.

## Operation
- The engine performs this copy for every r < num_rows and c < dst_row_len:
  - dst[dst_base + r*dst_row_len + c] = src[src_base + r*src_row_len + start_offset + c].
- Order is row-major: r is the outer loop and c the inner loop. One read is issued per cycle, with no bubbles between rows.
- State machine:
  - IDLE: waits for `cmd_valid`, then latches all command fields.
  - IDLE → DONE when num_rows==0 or dst_row_len==0. No SRAM access occurs.
  - IDLE → RUN otherwise.
  - RUN: issues one read per cycle. After the last read is issued, RUN → DRAIN.
  - DRAIN: performs the final write, then DRAIN → DONE.
  - DONE: asserts `done` for one cycle, then DONE → IDLE.
- Address generation uses running pointers only; no multipliers.
  - The source row pointer starts at src_base+start_offset and advances by src_row_len per row.
  - The destination pointer advances by 1 per byte.
  - The column counter and row counter are 16 bits each.
- Arithmetic is 16-bit modulo 2^16. Addresses are truncated to the low SRAM0_AW bits, so wrap-around is silent.
- Write pipeline:
  - The write address is the read address's destination counterpart, delayed one cycle.
  - `wr_data` = `rd_data` combinationally.
  - `wr_en` = `rd_en` delayed one cycle.
- `cmd_valid` is ignored in every state except IDLE. This includes the DONE cycle.
- Bounds are not checked. The engine reads past a row when start_offset+dst_row_len > src_row_len; guarding against this is the dispatcher's responsibility.
- In-place compaction is correct whenever every destination address is ≤ its source address. A read and a write to the same address never occur in the same cycle in that case.
- Asserting `rst_n` mid-command aborts the command immediately. The engine returns to IDLE with no `done` pulse, and SRAM contents already written remain.

## Timing
- Reset values: `rd_en`, `wr_en`, `busy` and `done` are 0. `rd_addr`, `wr_addr` and `wr_data` are 0; `wr_data` follows `rd_data` and is don't-care while `wr_en`=0. State is IDLE and all counters are 0.
- Let N = num_rows*dst_row_len, and let cycle 0 be the cycle in which `cmd_valid` is sampled in IDLE.
  - Reads (`rd_en`=1) occur in cycles 1..N.
  - Writes (`wr_en`=1) occur in cycles 2..N+1.
  - `done`=1 in cycle N+2.
- `busy` is 1 from cycle 1 through the `done` cycle inclusive. It is 0 in IDLE.
- Degenerate command (N=0): `done` and `busy` are both 1 in cycle 1 only, with no `rd_en` or `wr_en`.
- A back-to-back command may be sampled in the cycle after `done`, so the minimum command spacing is N+3 cycles.
- All outputs are registered except `wr_data`.

## Test plan
- **Basic 3×5 slice.** src_base=0x100 filled with 0..14, src_row_len=5, start_offset=1, dst_row_len=3, num_rows=3, dst_base=0x200.
  - Required: 0x200..0x208 = 1,2,3,6,7,8,11,12,13.
  - Required: `done` in cycle 11 and exactly 9 writes.
- **Zero rows.** num_rows=0.
  - Required: `done`=1 and `busy`=1 in cycle 1; no `rd_en` or `wr_en` ever asserted.
  - Repeat with dst_row_len=0 and num_rows=4: same response.
- **Ignored mid-command strobe.** Pulse `cmd_valid` with different fields during RUN.
  - Required: the first command's output is unchanged and exactly one `done` pulse occurs.
- **Wrap-around.** SRAM0_AW=16, src_base=0xFFFE, src_row_len=4, start_offset=0, dst_row_len=4, num_rows=1.
  - Required: reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Reset mid-command.** Drop `rst_n` in cycle 4 of a 20-byte copy.
  - Required: all outputs go to 0 asynchronously and no `done` pulse occurs.
  - Required: a new command issued after reset completes correctly.
- **In-place compaction.** src=dst_base=0x300 with rows of 8 bytes, start_offset=2, dst_row_len=4, num_rows=4.
  - Required: the first 16 bytes hold columns 2..5 of each original row.
